codificador: RTL and testbench

- Converts a 4-bit BCD digit on a,b,c,d (a = MSB) into its 5-symbol Morse code.
- Presents the code on five parallel outputs s1..s5, one per symbol.
- Also keys the same code serially on key_out with standard Morse timing.
- Sits between a digit source that qualifies data with ready and a display or transmitter stage.

---
 rtl/morse_pkg.sv | 13 +
 rtl/morse_keyer.sv | 51 +++++
 rtl/codificador.sv | 52 +++++
 tb/tb_codificador.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// morse_pkg: shared Morse code table, keyer state encoding and timing constants.
package morse_pkg;
  typedef enum logic [1:0] {IDLE, MARK, GAP, LGAP} key_state_t;
  localparam int DOT_UNITS        = 1;
  localparam int DASH_UNITS       = 3;
  localparam int SYM_GAP_UNITS    = 1;
  localparam int LETTER_GAP_UNITS = 3;
  // Symbol 1 in bit 4, 1 = dash
  localparam logic [4:0] CODES [10] = '{
    5'b11111, 5'b01111, 5'b00111, 5'b00011, 5'b00001,
    5'b00000, 5'b10000, 5'b11000, 5'b11100, 5'b11110
  };
endpackage

// File: rtl/morse_keyer.sv
// morse_keyer: serialises a 5-symbol Morse code onto a keying line with unit timing.
module morse_keyer import morse_pkg::*; #(
  parameter int UNIT_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic [4:0] i_code,
  output logic       o_key,
  output logic       o_busy
);
  key_state_t       r_state, w_state_n;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_sh;
  logic [2:0]       r_sym;
  int               w_units;
  logic             w_end;
  always_comb begin
    w_units = r_state == MARK ? (r_sh[4] ? DASH_UNITS : DOT_UNITS) :
              r_state == GAP  ? SYM_GAP_UNITS : LETTER_GAP_UNITS;
    w_end   = r_cnt == CNT_W'(UNIT_CYCLES * w_units - 1);
    w_state_n = r_state;
    case (r_state)
      IDLE:    w_state_n = i_start ? MARK : IDLE;
      MARK:    w_state_n = w_end ? (r_sym == 3'd4 ? LGAP : GAP) : MARK;
      GAP:     w_state_n = w_end ? MARK : GAP;
      default: w_state_n = w_end ? IDLE : LGAP;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_sym   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= (r_state == IDLE || w_end) ? '0 : r_cnt + CNT_W'(1);
      if (r_state == IDLE && i_start) begin
        r_sh  <= i_code;
        r_sym <= '0;
      end else if (r_state == MARK && w_end) begin
        r_sh  <= {r_sh[3:0], 1'b0};
        r_sym <= r_sym + 3'd1;
      end
    end
  end
  assign o_key  = r_state == MARK;
  assign o_busy = r_state != IDLE;
endmodule

// File: rtl/codificador.sv
// codificador: BCD digit to Morse code, parallel symbols plus serial keying.
module codificador import morse_pkg::*; #(
  parameter int UNIT_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic ready,
  output logic s1,
  output logic s2,
  output logic s3,
  output logic s4,
  output logic s5,
  output logic valid,
  output logic err,
  output logic key_out,
  output logic busy
);
  logic [3:0] w_digit;
  logic       w_ok, w_cap;
  logic [4:0] r_s;
  logic       r_valid, r_err;
  assign w_digit = {a, b, c, d};
  assign w_ok    = w_digit <= 4'd9;
  assign w_cap   = ready && w_ok;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s     <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_s     <= w_cap ? CODES[w_digit] : r_s;
      r_valid <= w_cap;
      r_err   <= ready ? !w_ok : r_err;
    end
  end
  morse_keyer #(.UNIT_CYCLES(UNIT_CYCLES), .CNT_W(CNT_W)) u_keyer (
    .clk    (clk),
    .rst_n  (reset_n),
    .i_start(w_cap),
    .i_code (CODES[w_digit]),
    .o_key  (key_out),
    .o_busy (busy)
  );
  assign {s1, s2, s3, s4, s5} = r_s;
  assign valid = r_valid;
  assign err   = r_err;
endmodule

// File: tb/tb_codificador.sv
// tb_codificador: directed checks of the Morse encoder, parallel table and keyer timing.
module tb_codificador;
  logic clk = 1'b0, reset_n = 1'b0, a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0, ready = 1'b0;
  logic s1, s2, s3, s4, s5, valid, err, key_out, busy;
  logic [4:0] s;
  int total = 0, bad = 0;
  assign s = {s1, s2, s3, s4, s5};
  always #5 clk = ~clk;
  codificador #(.UNIT_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .a(a), .b(b), .c(c), .d(d), .ready(ready),
    .s1(s1), .s2(s2), .s3(s3), .s4(s4), .s5(s5),
    .valid(valid), .err(err), .key_out(key_out), .busy(busy)
  );
  task automatic put(input logic [3:0] dig, input logic rdy);
    {a, b, c, d} = dig;
    ready = rdy;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL wait_idle: busy=%b want 0", busy);
    end
  endtask
  task automatic test_reset();
    #2;
    total++;
    if ({s, valid, err, key_out, busy} !== 9'b0) begin
      bad++;
      $display("FAIL reset_async: outs=%b want 000000000", {s, valid, err, key_out, busy});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({s, valid, err, key_out, busy} !== 9'b0) begin
        bad++;
        $display("FAIL reset_idle[%0d]: outs=%b want 000000000", i, {s, valid, err, key_out, busy});
      end
    end
  endtask
  task automatic test_table();
    logic [4:0] exp [10] = '{5'b11111, 5'b01111, 5'b00111, 5'b00011, 5'b00001,
                             5'b00000, 5'b10000, 5'b11000, 5'b11100, 5'b11110};
    for (int i = 0; i < 10; i++) begin
      put(4'(i), 1'b1);
      @(negedge clk);
      total++;
      if (s !== exp[i] || valid !== 1'b1 || err !== 1'b0) begin
        bad++;
        $display("FAIL table[%0d]: s=%b valid=%b err=%b want s=%b valid=1 err=0", i, s, valid, err, exp[i]);
      end
    end
    put(4'd0, 1'b0);
    @(negedge clk);
    total++;
    if (valid !== 1'b0 || s !== 5'b11110) begin
      bad++;
      $display("FAIL table_hold: s=%b valid=%b want s=11110 valid=0", s, valid);
    end
  endtask
  task automatic test_invalid();
    put(4'd7, 1'b1);
    @(negedge clk);
    total++;
    if (s !== 5'b11000 || valid !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("FAIL inv_pre7: s=%b valid=%b err=%b want 11000 1 0", s, valid, err);
    end
    put(4'd12, 1'b1);
    @(negedge clk);
    total++;
    if (s !== 5'b11000 || valid !== 1'b0 || err !== 1'b1) begin
      bad++;
      $display("FAIL inv_12: s=%b valid=%b err=%b want 11000 0 1", s, valid, err);
    end
    put(4'd0, 1'b0);
    @(negedge clk);
    total++;
    if (err !== 1'b1 || valid !== 1'b0) begin
      bad++;
      $display("FAIL inv_err_hold: err=%b valid=%b want 1 0", err, valid);
    end
    put(4'd4, 1'b1);
    @(negedge clk);
    total++;
    if (s !== 5'b00001 || valid !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("FAIL inv_post4: s=%b valid=%b err=%b want 00001 1 0", s, valid, err);
    end
    put(4'd0, 1'b0);
  endtask
  task automatic test_keyer_digit1();
    logic exp [$];
    wait_idle();
    repeat (2) exp.push_back(1'b1);
    repeat (2) exp.push_back(1'b0);
    for (int r = 0; r < 4; r++) begin
      repeat (6) exp.push_back(1'b1);
      repeat (2) exp.push_back(1'b0);
    end
    repeat (4) exp.push_back(1'b0);
    put(4'd1, 1'b1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      put(4'd0, 1'b0);
      total++;
      if (key_out !== exp[k] || busy !== 1'b1) begin
        bad++;
        $display("FAIL key1[%0d]: key=%b busy=%b want key=%b busy=1", k, key_out, busy, exp[k]);
      end
    end
    put(4'd2, 1'b1);
    @(negedge clk);
    put(4'd0, 1'b0);
    total++;
    if (busy !== 1'b0 || key_out !== 1'b0 || s !== 5'b00111 || valid !== 1'b1) begin
      bad++;
      $display("FAIL key1_end_capture: busy=%b key=%b s=%b valid=%b want 0 0 00111 1", busy, key_out, s, valid);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL key1_no_restart: busy=%b want 0", busy);
    end
  endtask
  task automatic test_busy_capture();
    logic exp [$];
    wait_idle();
    for (int r = 0; r < 5; r++) begin
      repeat (6) exp.push_back(1'b1);
      repeat (r < 4 ? 2 : 6) exp.push_back(1'b0);
    end
    put(4'd0, 1'b1);
    for (int k = 0; k < 44; k++) begin
      @(negedge clk);
      put(k == 3 ? 4'd6 : 4'd0, k == 3);
      total++;
      if (key_out !== exp[k] || busy !== 1'b1) begin
        bad++;
        $display("FAIL key0[%0d]: key=%b busy=%b want key=%b busy=1", k, key_out, busy, exp[k]);
      end
    end
    @(negedge clk);
    total++;
    if (s !== 5'b10000 || busy !== 1'b0) begin
      bad++;
      $display("FAIL key0_end: s=%b busy=%b want 10000 0", s, busy);
    end
  endtask
  task automatic test_async_reset();
    wait_idle();
    put(4'd0, 1'b1);
    @(negedge clk);
    put(4'd0, 1'b0);
    @(negedge clk);
    total++;
    if (key_out !== 1'b1 || s !== 5'b11111) begin
      bad++;
      $display("FAIL areset_pre: key=%b s=%b want 1 11111", key_out, s);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (key_out !== 1'b0 || busy !== 1'b0 || s !== 5'b0) begin
      bad++;
      $display("FAIL areset_now: key=%b busy=%b s=%b want 0 0 00000", key_out, busy, s);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || key_out !== 1'b0) begin
      bad++;
      $display("FAIL areset_after: busy=%b key=%b want 0 0", busy, key_out);
    end
  endtask
  initial begin
    test_reset();
    test_table();
    test_invalid();
    test_keyer_digit1();
    test_busy_capture();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
